// File: rtl/vga_scanhalver_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_scanhalver_if                                                  |
// | Video bundle between a VGA-timed source and the 15 kHz scanhalver. |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
interface vga_scanhalver_if;
  // 31 kHz VGA-rate input side
  logic [5:0] ri;
  logic [5:0] gi;
  logic [5:0] bi;
  logic       hsync_n;
  logic       vsync_n;
  // 15 kHz RGB output side
  logic [5:0] ro;
  logic [5:0] go;
  logic [5:0] bo;
  logic       hsync_o_n;
  logic       vsync_o_n;
  logic       csync_o_n;

  // Video source / output consumer
  modport master (
    output ri, gi, bi, hsync_n, vsync_n,
    input  ro, go, bo, hsync_o_n, vsync_o_n, csync_o_n
  );

  // Scanhalver itself
  modport slave (
    input  ri, gi, bi, hsync_n, vsync_n,
    output ro, go, bo, hsync_o_n, vsync_o_n, csync_o_n
  );
endinterface
`default_nettype wire

// File: rtl/vga_scanhalver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_scanhalver                                                     |
// | Converts 31 kHz VGA-rate video to 15 kHz RGB/CSYNC. Every other    |
// | input line is captured into one half of a 2 x 1024 line buffer     |
// | while the other half is replayed at half the pixel rate, so one    |
// | output line spans exactly two input lines.                         |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module vga_scanhalver #(
  parameter int CLKVGA      = 25000,
  parameter int HSYNC_COUNT = (CLKVGA * 4700 * 2) / 1000000,
  parameter int MIN_LINE    = 128
) (
  input wire              clkvga,
  input wire              rst,
  vga_scanhalver_if.slave vid
);

  // Counter widths and compare constants sized to their targets
  localparam int         c_HW       = $clog2(HSYNC_COUNT + 2);
  localparam logic [c_HW-1:0] c_HSYNC = c_HW'(HSYNC_COUNT);
  localparam logic [9:0] c_MIN_LINE = 10'(MIN_LINE);
  localparam logic [9:0] c_ADDR_MAX = 10'd1023;

  // ------------------------------------------------------------------
  // Input edge history
  // ------------------------------------------------------------------
  logic r_hs_prev;
  logic r_vs_prev;

  // ------------------------------------------------------------------
  // Write side state
  // ------------------------------------------------------------------
  logic [9:0] r_waddr;
  logic       r_parity;
  logic       r_wsel;
  logic [9:0] r_linelen;

  // ------------------------------------------------------------------
  // Read side state
  // ------------------------------------------------------------------
  logic [9:0]      r_raddr;
  logic            r_ce;
  logic            r_read_active;
  logic [c_HW-1:0] r_hcnt;

  // ------------------------------------------------------------------
  // Line buffer and output pipeline
  // ------------------------------------------------------------------
  logic [17:0] r_mem [0:2047];
  logic [17:0] r_dout;
  logic        r_active_d;
  logic        r_hsync_d;

  // ------------------------------------------------------------------
  // Combinational decode
  // ------------------------------------------------------------------
  logic        w_hs_fall;
  logic        w_edge;
  logic        w_vs_fall;
  logic        w_swap;
  logic        w_wr_en;
  logic [10:0] w_wr_addr;
  logic [10:0] w_rd_addr;

  // A falling hsync only counts as a line boundary once the current
  // line is long enough; short glitches inside a line are ignored.
  assign w_hs_fall = r_hs_prev & ~vid.hsync_n;
  assign w_edge    = w_hs_fall & (r_waddr >= c_MIN_LINE);
  assign w_vs_fall = r_vs_prev & ~vid.vsync_n;

  // An accepted edge closing an even line hands that line to the reader.
  assign w_swap    = w_edge & ~r_parity;

  // Only even lines are written; odd lines are timed but discarded.
  assign w_wr_en   = ~r_parity;
  assign w_wr_addr = {r_wsel, r_waddr};
  assign w_rd_addr = {~r_wsel, r_raddr};

  // Register previous hsync/vsync levels for edge detection; the vsync
  // copy doubles as the first stage of the output vsync pipeline.
  always_ff @(posedge clkvga) begin
    if (rst) begin
      r_hs_prev <= 1'b1;
      r_vs_prev <= 1'b1;
    end else begin
      r_hs_prev <= vid.hsync_n;
      r_vs_prev <= vid.vsync_n;
    end
  end

  // Track input pixel position and even/odd line parity.
  always_ff @(posedge clkvga) begin
    if (rst) begin
      r_waddr  <= '0;
      r_parity <= 1'b0;
    end else begin
      // Saturate rather than wrap so an overlong line cannot overwrite
      // the start of the captured data.
      if (w_edge) begin
        r_waddr <= '0;
      end else if (r_waddr != c_ADDR_MAX) begin
        r_waddr <= r_waddr + 10'd1;
      end

      // Frame start realigns parity so the first line of every frame
      // is captured; this takes priority over the toggle.
      if (w_vs_fall) begin
        r_parity <= 1'b0;
      end else if (w_edge) begin
        r_parity <= ~r_parity;
      end
    end
  end

  // Swap buffer halves on each captured line and replay at half rate.
  always_ff @(posedge clkvga) begin
    if (rst) begin
      r_wsel        <= 1'b0;
      r_linelen     <= '0;
      r_raddr       <= '0;
      r_ce          <= 1'b0;
      r_read_active <= 1'b0;
      r_hcnt        <= c_HSYNC;
    end else begin
      // Half-rate pixel enable
      r_ce <= ~r_ce;

      // Output hsync pulse timer; parks at the terminal count.
      if (r_hcnt < c_HSYNC) begin
        r_hcnt <= r_hcnt + 1'b1;
      end

      // Step through the stored line, one address per two clocks, and
      // stop on the last captured pixel.
      if (r_read_active && r_ce) begin
        if (r_raddr == r_linelen) begin
          r_read_active <= 1'b0;
        end else begin
          r_raddr <= r_raddr + 10'd1;
        end
      end

      // A new captured line restarts the reader from the beginning and
      // starts the output hsync pulse.
      if (w_swap) begin
        r_wsel        <= ~r_wsel;
        r_linelen     <= r_waddr;
        r_raddr       <= '0;
        r_ce          <= 1'b0;
        r_read_active <= 1'b1;
        r_hcnt        <= '0;
      end
    end
  end

  // Line buffer: write the live pixel, read the other half registered.
  // Contents are deliberately left untouched by reset.
  always_ff @(posedge clkvga) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= {vid.ri, vid.gi, vid.bi};
    end
    r_dout <= r_mem[w_rd_addr];
  end

  // Output registers: RGB and syncs share the same two-stage delay so
  // the hsync pulse lines up with the first replayed pixel.
  always_ff @(posedge clkvga) begin
    if (rst) begin
      r_active_d    <= 1'b0;
      r_hsync_d     <= 1'b1;
      vid.ro        <= '0;
      vid.go        <= '0;
      vid.bo        <= '0;
      vid.hsync_o_n <= 1'b1;
      vid.vsync_o_n <= 1'b1;
      vid.csync_o_n <= 1'b1;
    end else begin
      r_active_d    <= r_read_active;
      r_hsync_d     <= (r_hcnt >= c_HSYNC);
      // Blank beyond the end of the captured line
      vid.ro        <= r_active_d ? r_dout[17:12] : 6'd0;
      vid.go        <= r_active_d ? r_dout[11:6]  : 6'd0;
      vid.bo        <= r_active_d ? r_dout[5:0]   : 6'd0;
      vid.hsync_o_n <= r_hsync_d;
      vid.vsync_o_n <= r_vs_prev;
      vid.csync_o_n <= r_hsync_d & r_vs_prev;
    end
  end

endmodule
`default_nettype wire
